// File: rtl/gate_round_sequencer.sv
// gate_round_sequencer: key pulses, random gate draw, round countdown, miss blank-out and scoring
// for the logic-gate challenge game.
module gate_round_sequencer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int ROUND_TICKS  = 60,
    parameter int BLANK_CYCLES = 25_000_000,
    parameter int MAX_TRIES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch_n,
    input  logic       confirm_n,
    input  logic [3:0] rand_idx,
    output logic [8:0] selected_gate,
    output logic [8:0] current_gate,
    output logic [7:0] gate_code,
    output logic [8:0] completed_gate,
    output logic [3:0] score,
    output logic [6:0] time_left,
    output logic       timer_en,
    output logic       vga_blankout,
    output logic       game_won,
    output logic       game_lost
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int NW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {IDLE, PICK, PLAY, BLANK, WON, LOST} state_t;

    state_t        state_q, state_d;
    logic [1:0]    key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_prev_q, key_prev_d, pulse_q, pulse_d;
    logic [8:0]    sel_q, sel_d, cur_q, cur_d, done_q, done_d;
    logic [3:0]    score_q, score_d;
    logic [6:0]    tl_q, tl_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [NW-1:0] tries_q, tries_d;
    logic          timer_en_q, timer_en_d, vga_q, vga_d, won_q, won_d, lost_q, lost_d;
    logic          sw, cf, running, tick, expire, draw_ok, hit;
    logic [15:0]   done_ext;
    logic [8:0]    done_mask, fallback;

    always_comb begin
        key_s1_d   = {confirm_n, switch_n};
        key_s2_d   = key_s1_q;
        key_prev_d = key_s2_q;
        pulse_d    = key_prev_q & ~key_s2_q;
        sw         = pulse_q[0];
        cf         = pulse_q[1];
        running    = (state_q == PICK) || (state_q == PLAY) || (state_q == BLANK);
        tick       = running && (tick_q == TW'(TICK_DIV - 1));
        expire     = tick && (tl_q == 7'd1);
        done_ext   = {7'd0, done_q};
        draw_ok    = (rand_idx < 4'd9) && !done_ext[rand_idx];
        done_mask  = done_q | cur_q;
        // lowest clear bit of the completed set
        fallback   = ~done_q & (done_q + 9'd1);
        hit        = sel_q == cur_q;
        state_d    = state_q;
        sel_d      = (sw && state_q != WON && state_q != LOST) ? {sel_q[7:0], sel_q[8]} : sel_q;
        cur_d      = cur_q;
        done_d     = done_q;
        score_d    = score_q;
        tl_d       = tick ? tl_q - 7'd1 : tl_q;
        tick_d     = running ? (tick ? '0 : tick_q + TW'(1)) : tick_q;
        blank_d    = blank_q;
        tries_d    = tries_q;
        timer_en_d = timer_en_q;
        vga_d      = vga_q;
        won_d      = won_q;
        lost_d     = lost_q;
        case (state_q)
            IDLE: if (cf) begin
                state_d    = PICK;
                tl_d       = 7'(ROUND_TICKS);
                tick_d     = '0;
                tries_d    = '0;
                timer_en_d = 1'b1;
            end
            PICK: if (draw_ok) begin
                cur_d   = 9'd1 << rand_idx;
                state_d = PLAY;
            end else if (tries_q == NW'(MAX_TRIES - 1)) begin
                cur_d   = fallback;
                state_d = PLAY;
            end else begin
                tries_d = tries_q + NW'(1);
            end
            PLAY: if (cf && hit) begin
                done_d  = done_mask;
                score_d = score_q + 4'd1;
                tries_d = '0;
                state_d = (done_mask == 9'h1FF) ? WON : PICK;
                won_d   = done_mask == 9'h1FF;
                timer_en_d = done_mask != 9'h1FF;
            end else if (cf) begin
                state_d = BLANK;
                blank_d = BW'(BLANK_CYCLES);
                vga_d   = 1'b1;
            end
            BLANK: if (blank_q == BW'(1)) begin
                state_d = PLAY;
                vga_d   = 1'b0;
            end else begin
                blank_d = blank_q - BW'(1);
            end
            WON, LOST: if (cf) begin
                state_d = IDLE;
                done_d  = '0;
                score_d = '0;
                cur_d   = '0;
                won_d   = 1'b0;
                lost_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // a correct final confirm on the expiry tick still wins
        if (expire && state_d != WON) begin
            state_d    = LOST;
            lost_d     = 1'b1;
            timer_en_d = 1'b0;
            tl_d       = '0;
            vga_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            key_prev_q <= 2'b11;
            pulse_q    <= 2'b00;
            sel_q      <= 9'h001;
            cur_q      <= '0;
            done_q     <= '0;
            score_q    <= '0;
            tl_q       <= '0;
            tick_q     <= '0;
            blank_q    <= '0;
            tries_q    <= '0;
            timer_en_q <= 1'b0;
            vga_q      <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_prev_q <= key_prev_d;
            pulse_q    <= pulse_d;
            sel_q      <= sel_d;
            cur_q      <= cur_d;
            done_q     <= done_d;
            score_q    <= score_d;
            tl_q       <= tl_d;
            tick_q     <= tick_d;
            blank_q    <= blank_d;
            tries_q    <= tries_d;
            timer_en_q <= timer_en_d;
            vga_q      <= vga_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
        end
    end

    assign selected_gate  = sel_q;
    assign current_gate   = cur_q;
    assign gate_code      = cur_q[8:1];
    assign completed_gate = done_q;
    assign score          = score_q;
    assign time_left      = tl_q;
    assign timer_en       = timer_en_q;
    assign vga_blankout   = vga_q;
    assign game_won       = won_q;
    assign game_lost      = lost_q;
endmodule

// File: tb/tb_gate_round_sequencer.sv
// tb_gate_round_sequencer: directed and random stimulus against a game-level reference model.
module tb_gate_round_sequencer;
    localparam int TDIV = 4, ROUND = 5, BLANKC = 3, TRIES = 4;

    logic       clk = 1'b0, reset = 1'b0, switch_n = 1'b1, confirm_n = 1'b1;
    logic [3:0] rand_idx = 4'd0;
    logic [8:0] selected_gate, current_gate, completed_gate;
    logic [7:0] gate_code;
    logic [3:0] score;
    logic [6:0] time_left;
    logic       timer_en, vga_blankout, game_won, game_lost;

    gate_round_sequencer #(
        .TICK_DIV(TDIV), .ROUND_TICKS(ROUND), .BLANK_CYCLES(BLANKC), .MAX_TRIES(TRIES)
    ) dut (
        .clk(clk), .reset(reset), .switch_n(switch_n), .confirm_n(confirm_n), .rand_idx(rand_idx),
        .selected_gate(selected_gate), .current_gate(current_gate), .gate_code(gate_code),
        .completed_gate(completed_gate), .score(score), .time_left(time_left), .timer_en(timer_en),
        .vga_blankout(vga_blankout), .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    typedef enum {P_IDLE, P_PICK, P_PLAY, P_BLANK, P_WON, P_LOST} phase_t;
    phase_t     phase;
    int         m_sel, m_cur, m_tl, elapsed, tries, blank_left;
    logic [8:0] m_done;
    logic [4:0] sw_h, cf_h;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock edge of the game rules; key presses land three edges after first sampling low
    task automatic model_edge(input bit rs, input bit swl, input bit cfl, input int r);
        bit swp, cfp, run, expire;
        int old_sel, f;
        if (rs) begin
            phase = P_IDLE; m_sel = 0; m_cur = -1; m_done = '0; m_tl = 0;
            elapsed = 0; tries = 0; blank_left = 0; sw_h = '1; cf_h = '1;
            return;
        end
        sw_h = {sw_h[3:0], swl};
        cf_h = {cf_h[3:0], cfl};
        swp = !sw_h[3] && sw_h[4];
        cfp = !cf_h[3] && cf_h[4];
        old_sel = m_sel;
        if (swp && phase != P_WON && phase != P_LOST) m_sel = (m_sel + 1) % 9;
        run = phase == P_PICK || phase == P_PLAY || phase == P_BLANK;
        expire = 0;
        if (run) begin
            elapsed++;
            m_tl = ROUND - elapsed / TDIV;
            expire = elapsed == ROUND * TDIV;
        end
        case (phase)
            P_IDLE: if (cfp) begin phase = P_PICK; elapsed = 0; m_tl = ROUND; tries = 0; end
            P_PICK: if (r < 9 && !m_done[r]) begin
                m_cur = r; phase = P_PLAY;
            end else begin
                tries++;
                if (tries == TRIES) begin
                    f = -1;
                    for (int i = 8; i >= 0; i--) if (!m_done[i]) f = i;
                    m_cur = f; phase = P_PLAY;
                end
            end
            P_PLAY: if (cfp) begin
                if (old_sel == m_cur) begin
                    m_done[m_cur] = 1'b1;
                    if (&m_done) phase = P_WON;
                    else begin phase = P_PICK; tries = 0; end
                end else begin
                    phase = P_BLANK; blank_left = BLANKC;
                end
            end
            P_BLANK: begin blank_left--; if (blank_left == 0) phase = P_PLAY; end
            default: if (cfp) begin phase = P_IDLE; m_done = '0; m_cur = -1; end
        endcase
        if (expire && phase != P_WON) begin phase = P_LOST; m_tl = 0; end
    endtask

    task automatic check_all();
        logic [8:0] exp_cur;
        exp_cur = (m_cur < 0) ? 9'd0 : (9'd1 << m_cur);
        chk("selected", selected_gate, 9'd1 << m_sel);
        chk("current", current_gate, exp_cur);
        chk("code", {1'b0, gate_code}, {1'b0, exp_cur[8:1]});
        chk("completed", completed_gate, m_done);
        chk("score", {5'd0, score}, 9'($countones(m_done)));
        chk("time_left", {2'd0, time_left}, 9'(m_tl));
        chk("timer_en", {8'd0, timer_en}, 9'(phase == P_PICK || phase == P_PLAY || phase == P_BLANK));
        chk("vga", {8'd0, vga_blankout}, 9'(phase == P_BLANK));
        chk("won", {8'd0, game_won}, 9'(phase == P_WON));
        chk("lost", {8'd0, game_lost}, 9'(phase == P_LOST));
    endtask

    task automatic step(input bit rs, input bit swl, input bit cfl, input int r);
        @(negedge clk);
        reset = rs; switch_n = swl; confirm_n = cfl; rand_idx = 4'(r);
        @(posedge clk);
        model_edge(rs, swl, cfl, r);
        #1 check_all();
    endtask

    initial begin
        bit sl, cl;
        int r;
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        chk("rst_sel", selected_gate, 9'h001);
        chk("rst_timer", {8'd0, timer_en}, 9'd0);
        // start, miss, blank, rotations, combined press, expiry
        for (int k = 0; k < 26; k++) begin
            cl = !(k inside {0, 5, 7, 14});
            sl = !(k inside {8, 10, 12, 14});
            step(0, sl, cl, 3);
            if (k == 3) begin chk("t1_timer_en", {8'd0, timer_en}, 9'd1); chk("t1_tl", {2'd0, time_left}, 9'd5); end
            if (k == 4) begin chk("t1_current", current_gate, 9'h008); chk("t1_code", {1'b0, gate_code}, 9'h004); end
            if (k == 7) chk("t5_tick1", {2'd0, time_left}, 9'd4);
            if (k >= 8 && k <= 10) chk("t3_blank_hi", {8'd0, vga_blankout}, 9'd1);
            if (k == 11) begin
                chk("t3_blank_lo", {8'd0, vga_blankout}, 9'd0);
                chk("t3_done", completed_gate, 9'h000);
                chk("t3_score", {5'd0, score}, 9'd0);
            end
            if (k == 15) chk("t2_three", selected_gate, 9'h008);
            if (k == 17) begin
                chk("t2_rot", selected_gate, 9'h010);
                chk("t2_old_cmp", completed_gate, 9'h008);
                chk("t2_score", {5'd0, score}, 9'd1);
            end
            if (k == 22) chk("t5_not_yet", {8'd0, game_lost}, 9'd0);
            if (k == 23) begin
                chk("t5_lost", {8'd0, game_lost}, 9'd1);
                chk("t5_timer_off", {8'd0, timer_en}, 9'd0);
                chk("t5_tl0", {2'd0, time_left}, 9'd0);
            end
        end
        // four gates done, then fallback picks
        step(1, 1, 1, 0);
        for (int k = 0; k < 26; k++) begin
            cl = !(k inside {0, 2, 4, 6, 8, 13});
            sl = !(k inside {2, 4, 6, 8});
            r = (k <= 10) ? m_sel : ((k <= 15) ? 12 : 2);
            step(0, sl, cl, r);
            if (k == 11) begin chk("t4_done", completed_gate, 9'h00F); chk("t4_score", {5'd0, score}, 9'd4); end
            if (k == 14) chk("t4_pick3", current_gate, 9'h008);
            if (k == 15) chk("t4_fallback", current_gate, 9'h010);
            if (k == 16) chk("t4_done5", completed_gate, 9'h01F);
            if (k == 17) chk("t4_reject", current_gate, 9'h010);
            if (k == 20) chk("t4_fallback2", current_gate, 9'h020);
        end
        // untouched round runs out
        step(1, 1, 1, 0);
        for (int k = 0; k < 26; k++) begin
            step(0, 1, k != 0, $urandom_range(0, 15));
            if (k == 22) chk("t5b_not_yet", {8'd0, game_lost}, 9'd0);
            if (k == 23) begin chk("t5b_lost", {8'd0, game_lost}, 9'd1); chk("t5b_timer", {8'd0, timer_en}, 9'd0); end
        end
        // reset in the middle of a blank-out
        step(1, 1, 1, 0);
        for (int k = 0; k < 7; k++) begin
            step(k == 6, 1, !(k inside {0, 2}), 5);
            if (k == 5) chk("t5_blank_on", {8'd0, vga_blankout}, 9'd1);
            if (k == 6) begin
                chk("t5_rst_vga", {8'd0, vga_blankout}, 9'd0);
                chk("t5_rst_sel", selected_gate, 9'h001);
                chk("t5_rst_cur", current_gate, 9'h000);
                chk("t5_rst_tl", {2'd0, time_left}, 9'd0);
            end
        end
        step(0, 1, 1, 0);
        // random keys and draws
        for (int k = 0; k < 400; k++) begin
            sl = $urandom_range(0, 2) != 0;
            cl = $urandom_range(0, 2) != 0;
            r = $urandom_range(0, 1) ? m_sel : int'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, sl, cl, r);
        end
        // full win, then back to idle
        step(1, 1, 1, 0);
        for (int k = 0; k < 30; k++) begin
            cl = !((k % 2 == 0 && k <= 18) || k == 24);
            sl = !(k % 2 == 0 && k >= 2 && k <= 18);
            step(0, sl, cl, m_sel);
            if (k == 20) chk("t6_not_won", {8'd0, game_won}, 9'd0);
            if (k == 21) begin
                chk("t6_won", {8'd0, game_won}, 9'd1);
                chk("t6_score", {5'd0, score}, 9'd9);
                chk("t6_done", completed_gate, 9'h1FF);
                chk("t6_timer", {8'd0, timer_en}, 9'd0);
                chk("t2_wrap", selected_gate, 9'h001);
            end
            if (k == 27) begin
                chk("t6_idle_won", {8'd0, game_won}, 9'd0);
                chk("t6_idle_done", completed_gate, 9'h000);
                chk("t6_idle_score", {5'd0, score}, 9'd0);
                chk("t6_idle_cur", current_gate, 9'h000);
            end
        end
        // final confirm lands on the expiry tick
        for (int k = 0; k < 26; k++) begin
            cl = !(k == 0 || (k % 2 == 0 && k >= 4 && k <= 20));
            sl = !(k % 2 == 0 && k >= 4 && k <= 20);
            step(0, sl, cl, m_sel);
            if (k == 22) begin chk("t6b_pre", {8'd0, game_won}, 9'd0); chk("t6b_tl1", {2'd0, time_left}, 9'd1); end
            if (k == 23) begin
                chk("t6b_won", {8'd0, game_won}, 9'd1);
                chk("t6b_not_lost", {8'd0, game_lost}, 9'd0);
                chk("t6b_score", {5'd0, score}, 9'd9);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
